// File: rtl/alu_iter_if.sv
// alu_iter_if: operation request/response bundle between the control stage and alu_iter
//   master: start, op, a, b, shamt out; result, zero, busy, done, div_by_zero, hi in
//   slave:  the reverse (used by alu_iter)
interface alu_iter_if #(parameter int W = 32, parameter int SHW = 5);
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   result;
    logic           zero;
    logic           busy;
    logic           done;
    logic           div_by_zero;
    logic [W-1:0]   hi;
    modport master (output start, op, a, b, shamt, input result, zero, busy, done, div_by_zero, hi);
    modport slave (input start, op, a, b, shamt, output result, zero, busy, done, div_by_zero, hi);
endinterface

// File: rtl/alu_iter.sv
// alu_iter: execution ALU, single-cycle ADD/SUB/OR/AND/SLT/SLL, W-cycle shift-add MULT and restoring DIV
//   clk, rst (async, active-high); bus (alu_iter_if.slave): start/op/a/b/shamt in,
//   result/zero/busy/done/div_by_zero/hi out. Define ALU_ITER_HILO_EN to expose hi (upper product / remainder).
module alu_iter #(
    parameter int W   = 32,
    parameter int SHW = 5
) (
    input  logic clk,
    input  logic rst,
    alu_iter_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011;
    localparam logic [2:0] OP_OR = 3'b100, OP_AND = 3'b101, OP_SLT = 3'b110, OP_SLL = 3'b111;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t       state;
    logic [CW-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0] dvsr;
    logic         is_div;
    logic [W:0]   sum, shf, dif;
    logic [2*W-1:0] step;
    logic [W-1:0] quick;
    logic         multi, fin_run, fin_quick;
    // acc holds {product high, multiplier} for MULT and {remainder, dividend/quotient} for DIV
    always_comb begin
        sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, dvsr} : '0);
        shf  = acc[2*W-1:W-1];
        dif  = shf - {1'b0, dvsr};
        step = is_div ? (dif[W] ? {shf[W-1:0], acc[W-2:0], 1'b0} : {dif[W-1:0], acc[W-2:0], 1'b1})
                      : {sum, acc[W-1:1]};
        // anything not listed falls to all ones, which is exactly the DIV-by-zero result
        quick = bus.op == OP_ADD ? bus.a + bus.b :
                bus.op == OP_SUB ? bus.a - bus.b :
                bus.op == OP_OR  ? bus.a | bus.b :
                bus.op == OP_AND ? bus.a & bus.b :
                bus.op == OP_SLT ? {{(W-1){1'b0}}, $signed(bus.a) < $signed(bus.b)} :
                bus.op == OP_SLL ? (32'(bus.shamt) >= W ? '0 : bus.b << bus.shamt) : '1;
        multi     = bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0);
        fin_run   = state == RUN && cnt == '0;
        fin_quick = state != RUN && bus.start && !multi;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            dvsr            <= '0;
            is_div          <= 1'b0;
            bus.result      <= '0;
            bus.zero        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else if (state == RUN) begin
            acc <= step;
            cnt <= cnt - 1'b1;
            if (fin_run) begin
                bus.result      <= step[W-1:0];
                bus.zero        <= step[W-1:0] == '0;
                bus.div_by_zero <= 1'b0;
                bus.busy        <= 1'b0;
                bus.done        <= 1'b1;
                state           <= FIN;
            end
        end else if (bus.start && multi) begin
            is_div   <= bus.op == OP_DIV;
            dvsr     <= bus.op == OP_DIV ? bus.b : bus.a;
            acc      <= {{W{1'b0}}, bus.op == OP_DIV ? bus.a : bus.b};
            cnt      <= CW'(W - 1);
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
            state    <= RUN;
        end else if (bus.start) begin
            bus.result      <= quick;
            bus.zero        <= quick == '0;
            bus.div_by_zero <= bus.op == OP_DIV;
            bus.done        <= 1'b1;
            state           <= FIN;
        end else begin
            bus.done <= 1'b0;
            state    <= IDLE;
        end
    end
`ifdef ALU_ITER_HILO_EN
    logic [W-1:0] hi_q;
    // single-cycle completions clear hi, except DIV by zero which reports the dividend
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hi_q <= '0;
        else if (fin_run) hi_q <= step[2*W-1:W];
        else if (fin_quick) hi_q <= bus.op == OP_DIV ? bus.a : '0;
    end
    assign bus.hi = hi_q;
`else
    assign bus.hi = '0;
`endif
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: vector table, random ops against an arithmetic model, and handshake corner sequences
module tb_alu_iter;
    localparam int W = 32;
`ifdef ALU_ITER_HILO_EN
    localparam bit HILO = 1'b1;
`else
    localparam bit HILO = 1'b0;
`endif
    logic clk, rst;
    int total = 0, bad = 0;
    alu_iter_if #(.W(W), .SHW(5)) bus ();
    alu_iter #(.W(W), .SHW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] er, eh;
        bit          edz;
        int          elat;
    } vec_t;
    vec_t tv[15];

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, got, want);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] s, output logic [31:0] r, output logic [31:0] h,
                                  output bit dz, output int lat);
        logic [63:0] p;
        h = 0; dz = 0; lat = 1;
        p = 64'(x) * 64'(y);
        case (o)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: begin r = p[31:0]; h = p[63:32]; lat = 33; end
            3'd3: if (y == 0) begin r = '1; h = x; dz = 1; end
                  else begin r = x / y; h = x % y; lat = 33; end
            3'd4: r = x | y;
            3'd5: r = x & y;
            3'd6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: r = (int'(s) >= W) ? 32'd0 : y << s;
        endcase
        if (!HILO) h = 0;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] s, output int lat, output int busy_n);
        @(negedge clk);
        bus.op = o; bus.a = x; bus.b = y; bus.shamt = s; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 1; busy_n = 0;
        while (!bus.done && lat < 100) begin
            busy_n += int'(bus.busy);
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic run_chk(input string n, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] s, input logic [31:0] er, input logic [31:0] eh,
                           input bit edz, input int elat);
        int lat, bn;
        do_op(o, x, y, s, lat, bn);
        chk({n, " latency"}, lat, elat);
        chk({n, " result"}, bus.result, er);
        chk({n, " zero"}, bus.zero, er == 0);
        chk({n, " hi"}, bus.hi, HILO ? eh : 32'd0);
        chk({n, " dbz"}, bus.div_by_zero, edz);
        chk({n, " busy cycles"}, bn, elat == 33 ? 32 : 0);
        @(posedge clk);
        #1 chk({n, " done width"}, bus.done, 0);
    endtask

    initial begin
        logic [31:0] r, h, x, y;
        logic [2:0]  o;
        logic [4:0]  s;
        bit          dz;
        int          lat, nd, dlat;
        tv[0]  = '{3'd0, 32'd5, 32'd7, 5'd0, 32'd12, 32'd0, 1'b0, 1};
        tv[1]  = '{3'd1, 32'd3, 32'd3, 5'd0, 32'd0, 32'd0, 1'b0, 1};
        tv[2]  = '{3'd0, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd1, 32'd0, 1'b0, 1};
        tv[3]  = '{3'd1, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF, 32'd0, 1'b0, 1};
        tv[4]  = '{3'd4, 32'hF0F0, 32'h0F0F, 5'd0, 32'hFFFF, 32'd0, 1'b0, 1};
        tv[5]  = '{3'd5, 32'hF0F0, 32'h0FF0, 5'd0, 32'h00F0, 32'd0, 1'b0, 1};
        tv[6]  = '{3'd6, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 32'd0, 1'b0, 1};
        tv[7]  = '{3'd6, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 32'd0, 1'b0, 1};
        tv[8]  = '{3'd7, 32'd0, 32'd1, 5'd31, 32'h80000000, 32'd0, 1'b0, 1};
        tv[9]  = '{3'd7, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1};
        tv[10] = '{3'd2, 32'h10000, 32'h30000, 5'd0, 32'd0, 32'd3, 1'b0, 33};
        tv[11] = '{3'd3, 32'd100, 32'd7, 5'd0, 32'd14, 32'd2, 1'b0, 33};
        tv[12] = '{3'd3, 32'd9, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd9, 1'b1, 1};
        tv[13] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'd1, 32'hFFFFFFFE, 1'b0, 33};
        tv[14] = '{3'd3, 32'd7, 32'd100, 5'd0, 32'd0, 32'd7, 1'b0, 33};

        rst = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
        #12;
        chk("reset result", bus.result, 0);
        chk("reset zero", bus.zero, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset dbz", bus.div_by_zero, 0);
        chk("reset hi", bus.hi, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            run_chk($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].sh,
                    tv[i].er, tv[i].eh, tv[i].edz, tv[i].elat);

        // back-to-back: SUB completes, SLT launched from FIN with start held
        @(negedge clk);
        bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b sub done", bus.done, 1);
        chk("b2b sub result", bus.result, 0);
        chk("b2b sub zero", bus.zero, 1);
        bus.op = 3'd6; bus.a = 32'hFFFFFFFF; bus.b = 32'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("b2b slt done", bus.done, 1);
        chk("b2b slt result", bus.result, 1);
        chk("b2b slt zero", bus.zero, 0);

        // MULT with start pulses and operand churn during RUN
        @(negedge clk);
        bus.op = 3'd2; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        nd = 0; dlat = 0; r = '0;
        for (int c = 1; c <= 45; c++) begin
            if (bus.done) begin nd++; dlat = c; r = bus.result; end
            if (c >= 5 && c < 20) begin
                bus.start = c[0]; bus.op = 3'(c % 8); bus.a = $urandom; bus.b = $urandom;
            end else bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("churn done count", nd, 1);
        chk("churn latency", dlat, 33);
        chk("churn result", r, 42);

        // random ops against the model
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = 0;
                1: y = $urandom_range(1, 20);
                default: y = $urandom;
            endcase
            if (o == 3'd2 && y == 0) y = 1;
            if ($urandom_range(0, 3) == 0) x = y;
            s = 5'($urandom_range(0, 31));
            model(o, x, y, s, r, h, dz, lat);
            run_chk($sformatf("rnd%0d op%0d a=%0h b=%0h", i, o, x, y), o, x, y, s, r, h, dz, lat);
        end

        // reset in the middle of RUN after a DIV-by-zero left flags set
        run_chk("pre-reset div0", 3'd3, 32'd9, 32'd0, 5'd0, 32'hFFFFFFFF, 32'd9, 1'b1, 1);
        @(negedge clk);
        bus.op = 3'd2; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3 chk("mid-run busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("abort result", bus.result, 0);
        chk("abort zero", bus.zero, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort dbz", bus.div_by_zero, 0);
        chk("abort hi", bus.hi, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1 nd += int'(bus.done);
        end
        chk("abort no done", nd, 0);
        run_chk("post-reset add", 3'd0, 32'd1, 32'd1, 5'd0, 32'd2, 32'd0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
